// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO-side arbiters (write arbiter, read scheduler).
// No logic here: state encodings, default sizing and a constant-evaluable clog2.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

   localparam int DEF_NREQ     = 4;
   localparam int DEF_DATALEN  = 8;
   localparam int DEF_BURSTLEN = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set req bit after last_id, wrapping modulo NREQ.
// Purely combinational; no backpressure of its own.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_id,
   output logic            any,
   output logic [IDW-1:0]  pick_id
);

   logic [IDW-1:0] idx;

   // Scan from farthest to nearest so the nearest candidate is written last and wins.
   always_comb begin
      any     = 1'b0;
      pick_id = '0;
      idx     = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IDW'((int'(last_id) + k) % NREQ);
         if (req[idx]) begin
            any     = 1'b1;
            pick_id = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; grant one cycle after request seen in IDLE.
// Backpressure: wfull holds the current grant (no write, no accept) and never releases it.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ     = DEF_NREQ,
   parameter int DATALEN  = DEF_DATALEN,
   parameter int BURSTLEN = DEF_BURSTLEN
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*DATALEN-1:0]    req_data,
   output logic [NREQ-1:0]            req_ready,
   input  logic                       wfull,
   output logic                       winc,
   output logic [DATALEN-1:0]         wdata,
   output logic [NREQ-1:0]            grant,
   output logic [clog2(NREQ)-1:0]     grant_id,
   output logic                       busy
);

   localparam int IDW = clog2(NREQ);
   localparam int CW  = (clog2(BURSTLEN) > 0) ? clog2(BURSTLEN) : 1;

   arb_state_t          state;
   logic [CW-1:0]       burst_cnt;
   logic [IDW-1:0]      last_id;

   logic                pick_any;
   logic [IDW-1:0]      pick_id;
   logic [NREQ-1:0]     pick_oh;
   logic                xfer;
   logic                burst_last;
   logic [DATALEN-1:0]  req_slice [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign req_slice[i] = req_data[i*DATALEN +: DATALEN];
   end

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req     (req_valid),
      .last_id (last_id),
      .any     (pick_any),
      .pick_id (pick_id)
   );

   assign pick_oh    = {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
   assign burst_last = (burst_cnt == CW'(BURSTLEN - 1));
   assign busy       = (state == ST_BURST);

   // rst gates the strobe so an aborted burst never writes on the reset edge.
   always_comb begin
      xfer      = (state == ST_BURST) && req_valid[grant_id] && !wfull && !rst;
      winc      = xfer;
      req_ready = xfer ? grant : '0;
      wdata     = xfer ? req_slice[grant_id] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         grant     <= '0;
         grant_id  <= '0;
         burst_cnt <= '0;
         last_id   <= IDW'(NREQ - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  state     <= ST_BURST;
                  grant     <= pick_oh;
                  grant_id  <= pick_id;
                  burst_cnt <= '0;
               end
            end
            ST_BURST: begin
               if (!req_valid[grant_id]) begin
                  state   <= ST_IDLE;
                  grant   <= '0;
                  last_id <= grant_id;
               end else if (xfer) begin
                  burst_cnt <= burst_cnt + 1'b1;
                  if (burst_last) begin
                     state   <= ST_IDLE;
                     grant   <= '0;
                     last_id <= grant_id;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule
